// File: rtl/noc_pkg.sv
// Shared FSM state type and flit field helpers for the mesh NoC processing element.
package noc_pkg;

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} tx_state_e;

  // Flits are built at this width and then truncated to the instance's FLIT_W.
  localparam int unsigned FlitMaxW = 64;

  function automatic int unsigned id_width(input int unsigned num_nodes);
    return (num_nodes > 1) ? $clog2(num_nodes) : 1;
  endfunction

  function automatic int unsigned dest_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned src_lsb(input int unsigned id_w, input int unsigned data_w);
    return id_w + data_w;
  endfunction

  // Flit layout, MSB first: {src, dest, payload}.
  function automatic logic [FlitMaxW-1:0] pack_flit(input int unsigned        id_w,
                                                     input int unsigned        data_w,
                                                     input logic [31:0]        src,
                                                     input logic [31:0]        dest,
                                                     input logic [FlitMaxW-1:0] payload);
    logic [FlitMaxW-1:0] id_mask;
    logic [FlitMaxW-1:0] data_mask;
    id_mask   = (FlitMaxW'(1) << id_w) - FlitMaxW'(1);
    data_mask = (FlitMaxW'(1) << data_w) - FlitMaxW'(1);
    return ((FlitMaxW'(src) & id_mask) << src_lsb(id_w, data_w)) |
           ((FlitMaxW'(dest) & id_mask) << dest_lsb(data_w)) |
           (payload & data_mask);
  endfunction

endpackage

// File: rtl/noc_rx_scoreboard.sv
// Receive side of the PE: saturating flit counter plus, with NOC_PE_SCOREBOARD_EN defined,
// a per-source expected-sequence table that counts out-of-order or misrouted flits.
module noc_rx_scoreboard
  import noc_pkg::*;
#(
  parameter int unsigned ID_W   = 2,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned FLIT_W = 2 * ID_W + DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ID_W-1:0]   my_id,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic [15:0]       rx_count,
  output logic [15:0]       rx_err_count
);

  logic [15:0] rx_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_count_q <= '0;
    end else if (in_valid && (rx_count_q != 16'hFFFF)) begin
      rx_count_q <= rx_count_q + 16'd1;
    end
  end

  assign rx_count = rx_count_q;

`ifdef NOC_PE_SCOREBOARD_EN
  // One entry per encodable source ID, which covers every node in the mesh.
  localparam int unsigned Entries = 2 ** ID_W;

  logic [ID_W-1:0]   src;
  logic [ID_W-1:0]   dest;
  logic [DATA_W-1:0] payload;
  logic [DATA_W-1:0] exp_q [Entries];
  logic [15:0]       err_q;
  logic              mismatch;

  assign src      = in_flit[FLIT_W-1 -: ID_W];
  assign dest     = in_flit[DATA_W +: ID_W];
  assign payload  = in_flit[DATA_W-1:0];
  assign mismatch = (payload != exp_q[src]) || (dest != my_id);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Entries; i++) begin
        exp_q[i] <= '0;
      end
      err_q <= '0;
    end else if (in_valid) begin
      // Resync on every flit so one dropped flit is reported once, not forever.
      exp_q[src] <= payload + 1'b1;
      if (mismatch && (err_q != 16'hFFFF)) begin
        err_q <= err_q + 16'd1;
      end
    end
  end

  assign rx_err_count = err_q;
`else
  logic unused_flit;
  assign unused_flit  = ^{in_flit, my_id};
  assign rx_err_count = '0;
`endif

endmodule

// File: rtl/noc_pe_traffic_gen.sv
// Processing-element traffic generator/sink for one mesh NoC router local port.
// Define NOC_PE_SCOREBOARD_EN to enable per-source sequence checking of received flits.
module noc_pe_traffic_gen
  import noc_pkg::*;
#(
  parameter int unsigned NUM_NODES = 4,
  parameter int unsigned MY_ID     = 0,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned INJ_GAP   = 0,
  localparam int unsigned ID_W   = id_width(NUM_NODES),
  localparam int unsigned CFG_W  = 1 + ID_W + CNT_W,
  localparam int unsigned FLIT_W = 2 * ID_W + DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CFG_W-1:0]  pe_configure,
  output logic              pe_ready,
  output logic              tx_done,
  output logic              cfg_err,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [15:0]       rx_count,
  output logic [15:0]       rx_err_count
);

  localparam int unsigned GAP_W = (INJ_GAP > 1) ? $clog2(INJ_GAP + 1) : 1;

  logic              go;
  logic              go_q;
  logic              start;
  logic [ID_W-1:0]   cfg_dest;
  logic [CNT_W-1:0]  cfg_count;
  tx_state_e         state_q, state_d;
  logic [ID_W-1:0]   dest_q, dest_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [DATA_W-1:0] seq_q, seq_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              cfg_err_q, cfg_err_d;

  assign go        = pe_configure[CFG_W-1];
  assign cfg_dest  = pe_configure[CNT_W +: ID_W];
  assign cfg_count = pe_configure[CNT_W-1:0];
  // Only a rising edge of go requests a burst; a held level never retriggers.
  assign start     = go & ~go_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      go_q      <= 1'b0;
      dest_q    <= '0;
      remain_q  <= '0;
      seq_q     <= '0;
      gap_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      go_q      <= go;
      dest_q    <= dest_d;
      remain_q  <= remain_d;
      seq_q     <= seq_d;
      gap_q     <= gap_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    remain_d  = remain_q;
    seq_d     = seq_q;
    gap_d     = gap_q;
    cfg_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if ((cfg_count == '0) || (cfg_dest == ID_W'(MY_ID))) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d  = StSend;
            dest_d   = cfg_dest;
            remain_d = cfg_count;
            seq_d    = '0;
          end
        end
      end
      StSend: begin
        if (out_ready) begin
          seq_d    = seq_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == CNT_W'(1)) begin
            state_d = StDone;
          end else if (INJ_GAP > 0) begin
            state_d = StGap;
            gap_d   = GAP_W'(INJ_GAP - 1);
          end
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StSend;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  assign pe_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StSend);
  assign tx_done   = (state_q == StDone);
  assign cfg_err   = cfg_err_q;
  assign in_ready  = 1'b1;
  assign out_flit  = out_valid ?
                     FLIT_W'(pack_flit(ID_W, DATA_W, 32'(MY_ID), 32'(dest_q), FlitMaxW'(seq_q))) :
                     '0;

  noc_rx_scoreboard #(
    .ID_W   (ID_W),
    .DATA_W (DATA_W)
  ) u_rx_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .my_id        (ID_W'(MY_ID)),
    .in_flit      (in_flit),
    .in_valid     (in_valid),
    .rx_count     (rx_count),
    .rx_err_count (rx_err_count)
  );

endmodule

// File: tb/tb_noc_pe_traffic_gen.sv
// Directed self-checking bench: one back-to-back generator (MY_ID=0) and one with INJ_GAP=2 (MY_ID=1).
module tb_noc_pe_traffic_gen;

  localparam int unsigned IdW   = 2;
  localparam int unsigned CntW  = 8;
  localparam int unsigned DataW = 8;
  localparam int unsigned CfgW  = 1 + IdW + CntW;
  localparam int unsigned FlitW = 2 * IdW + DataW;

  logic             clock = 1'b0;
  logic             reset;
  logic [CfgW-1:0]  cfg, cfg_g;
  logic             pe_ready, tx_done, cfg_err, out_valid, out_ready, in_valid, in_ready;
  logic             pe_ready_g, tx_done_g, cfg_err_g, out_valid_g, out_ready_g, in_ready_g;
  logic [FlitW-1:0] out_flit, in_flit, out_flit_g, in_flit_g;
  logic [15:0]      rx_count, rx_err_count, rx_count_g, rx_err_count_g;

  int checks = 0;
  int errors = 0;
  int hs_cnt;
  int hs_base;

  always #5 clock = ~clock;

  noc_pe_traffic_gen #(
    .NUM_NODES (4),
    .MY_ID     (0),
    .CNT_W     (CntW),
    .DATA_W    (DataW),
    .INJ_GAP   (0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pe_configure (cfg),
    .pe_ready     (pe_ready),
    .tx_done      (tx_done),
    .cfg_err      (cfg_err),
    .out_flit     (out_flit),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .in_flit      (in_flit),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rx_count     (rx_count),
    .rx_err_count (rx_err_count)
  );

  noc_pe_traffic_gen #(
    .NUM_NODES (4),
    .MY_ID     (1),
    .CNT_W     (CntW),
    .DATA_W    (DataW),
    .INJ_GAP   (2)
  ) dut_gap (
    .clock        (clock),
    .reset        (reset),
    .pe_configure (cfg_g),
    .pe_ready     (pe_ready_g),
    .tx_done      (tx_done_g),
    .cfg_err      (cfg_err_g),
    .out_flit     (out_flit_g),
    .out_valid    (out_valid_g),
    .out_ready    (out_ready_g),
    .in_flit      (in_flit_g),
    .in_valid     (1'b0),
    .in_ready     (in_ready_g),
    .rx_count     (rx_count_g),
    .rx_err_count (rx_err_count_g)
  );

  always @(posedge clock or posedge reset) begin
    if (reset) hs_cnt <= 0;
    else if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [CfgW-1:0] cfg_word(input logic go, input logic [IdW-1:0] dest,
                                               input logic [CntW-1:0] count);
    return {go, dest, count};
  endfunction

  initial begin
    reset = 1'b0; cfg = '0; cfg_g = '0; out_ready = 1'b0; out_ready_g = 1'b0;
    in_valid = 1'b0; in_flit = '0; in_flit_g = '0;
    #2 reset = 1'b1;
    #2;
    check_eq("rst_pe_ready", 32'(pe_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_flit", 32'(out_flit), 32'd0);
    check_eq("rst_tx_done", 32'(tx_done), 32'd0);
    check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
    check_eq("rst_rx_count", 32'(rx_count), 32'd0);
    check_eq("rst_rx_err", 32'(rx_err_count), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0;

    // 1: three back-to-back flits to node 2
    cfg = cfg_word(1'b1, 2'd2, 8'd3); out_ready = 1'b1;
    tick(); check_eq("t1_valid0", 32'(out_valid), 32'd1);
    check_eq("t1_flit0", 32'(out_flit), 32'h200);
    check_eq("t1_busy", 32'(pe_ready), 32'd0);
    tick(); check_eq("t1_flit1", 32'(out_flit), 32'h201);
    tick(); check_eq("t1_flit2", 32'(out_flit), 32'h202);
    tick(); check_eq("t1_done", 32'(tx_done), 32'd1);
    check_eq("t1_done_nv", 32'(out_valid), 32'd0);
    tick(); check_eq("t1_done_off", 32'(tx_done), 32'd0);
    check_eq("t1_ready", 32'(pe_ready), 32'd1);
    tick(); check_eq("t1_go_held", 32'(out_valid), 32'd0);

    // 2: backpressure on flit 1 for five cycles
    cfg = '0; tick();
    hs_base = hs_cnt;
    cfg = cfg_word(1'b1, 2'd2, 8'd3);
    tick(); check_eq("t2_flit0", 32'(out_flit), 32'h200);
    tick(); check_eq("t2_flit1", 32'(out_flit), 32'h201);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t2_stall_valid", 32'(out_valid), 32'd1);
      check_eq("t2_stall_flit", 32'(out_flit), 32'h201);
    end
    out_ready = 1'b1;
    tick(); check_eq("t2_flit2", 32'(out_flit), 32'h202);
    tick(); check_eq("t2_done", 32'(tx_done), 32'd1);
    check_eq("t2_handshakes", 32'(hs_cnt - hs_base), 32'd3);
    tick(); check_eq("t2_ready", 32'(pe_ready), 32'd1);

    // 3: rejected requests
    cfg = '0; tick();
    cfg = cfg_word(1'b1, 2'd2, 8'd0);
    tick(); check_eq("t3_cnt0_err", 32'(cfg_err), 32'd1);
    check_eq("t3_cnt0_nv", 32'(out_valid), 32'd0);
    check_eq("t3_cnt0_rdy", 32'(pe_ready), 32'd1);
    cfg = '0;
    tick(); check_eq("t3_err_pulse", 32'(cfg_err), 32'd0);
    cfg = cfg_word(1'b1, 2'd0, 8'd5);
    tick(); check_eq("t3_self_err", 32'(cfg_err), 32'd1);
    check_eq("t3_self_nv", 32'(out_valid), 32'd0);
    cfg = '0;
    tick(); check_eq("t3_self_off", 32'(cfg_err), 32'd0);
    check_eq("t3_rdy", 32'(pe_ready), 32'd1);

    // 4: go edge mid-burst ignored; gap instance inserts two idle cycles
    cfg = cfg_word(1'b1, 2'd2, 8'd4);
    tick(); check_eq("t4_flit0", 32'(out_flit), 32'h200);
    cfg = cfg_word(1'b0, 2'd2, 8'd4);
    tick(); check_eq("t4_flit1", 32'(out_flit), 32'h201);
    cfg = cfg_word(1'b1, 2'd3, 8'd9);
    tick(); check_eq("t4_flit2", 32'(out_flit), 32'h202);
    check_eq("t4_no_err", 32'(cfg_err), 32'd0);
    tick(); check_eq("t4_flit3", 32'(out_flit), 32'h203);
    tick(); check_eq("t4_done", 32'(tx_done), 32'd1);
    tick(); check_eq("t4_ready", 32'(pe_ready), 32'd1);
    tick(); check_eq("t4_no_rerun", 32'(out_valid), 32'd0);

    cfg_g = cfg_word(1'b1, 2'd3, 8'd2); out_ready_g = 1'b1;
    tick(); check_eq("t4g_flit0", 32'(out_flit_g), 32'h700);
    check_eq("t4g_valid0", 32'(out_valid_g), 32'd1);
    tick(); check_eq("t4g_gap1", 32'(out_valid_g), 32'd0);
    tick(); check_eq("t4g_gap2", 32'(out_valid_g), 32'd0);
    tick(); check_eq("t4g_flit1", 32'(out_flit_g), 32'h701);
    check_eq("t4g_valid1", 32'(out_valid_g), 32'd1);
    tick(); check_eq("t4g_done", 32'(tx_done_g), 32'd1);
    tick(); check_eq("t4g_ready", 32'(pe_ready_g), 32'd1);

    // 5: reset mid-burst, then a fresh burst restarts at seq 0
    cfg = '0; tick();
    cfg = cfg_word(1'b1, 2'd2, 8'd5);
    tick(); check_eq("t5_flit0", 32'(out_flit), 32'h200);
    tick(); check_eq("t5_flit1", 32'(out_flit), 32'h201);
    #1 reset = 1'b1;
    #1;
    check_eq("t5_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t5_rst_ready", 32'(pe_ready), 32'd1);
    check_eq("t5_rst_flit", 32'(out_flit), 32'd0);
    cfg = '0;
    tick();
    reset = 1'b0;
    tick(); check_eq("t5_no_done", 32'(tx_done), 32'd0);
    cfg = cfg_word(1'b1, 2'd2, 8'd2);
    tick(); check_eq("t5_new_flit0", 32'(out_flit), 32'h200);
    tick(); check_eq("t5_new_flit1", 32'(out_flit), 32'h201);
    tick(); check_eq("t5_new_done", 32'(tx_done), 32'd1);
    cfg = '0;

    // 6: receive path, src 1 payloads 0,1,3 then a misrouted flit from src 2
    in_valid = 1'b1; in_flit = 12'h400;
    tick(); in_flit = 12'h401;
    tick(); in_flit = 12'h403;
    tick();
    check_eq("t6_rx3", 32'(rx_count), 32'd3);
`ifdef NOC_PE_SCOREBOARD_EN
    check_eq("t6_err3", 32'(rx_err_count), 32'd1);
`else
    check_eq("t6_err3", 32'(rx_err_count), 32'd0);
`endif
    in_flit = 12'h900;
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("t6_rx4", 32'(rx_count), 32'd4);
`ifdef NOC_PE_SCOREBOARD_EN
    check_eq("t6_err4", 32'(rx_err_count), 32'd2);
`else
    check_eq("t6_err4", 32'(rx_err_count), 32'd0);
`endif
    check_eq("t6_gap_rx", 32'(rx_count_g), 32'd0);
    check_eq("t6_in_ready", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
